// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: RO-stage issue control for five execution units plus a
// fixed-priority common-data-bus arbiter. Each unit is a small IDLE/BUSY/DONE
// tracker; the top decodes the target, arbitrates the CDB and decides issue.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

// Per-unit tracker: latency countdown, result tag, and hold-in-DONE until the
// CDB is granted.
module fu_unit #(
  parameter int         ROB_W = 6,
  parameter logic [3:0] LAT   = 4'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             issue,
  input  logic             grant,
  input  logic [ROB_W-1:0] tag_in,
  output logic             idle,
  output logic             done,
  output logic [ROB_W-1:0] tag
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [ROB_W-1:0] tag_nxt;

  // State, counter and tag registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      tag   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tag   <= tag_nxt;
    end
  end

  // Next state: flush beats everything, EN low holds, issue beats retire so a
  // granted DONE unit can be refilled in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tag_nxt   = tag;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      tag_nxt   = '0;
    end else if (en) begin
      if (issue) begin
        state_nxt = BUSY;
        cnt_nxt   = LAT;
        tag_nxt   = tag_in;
      end else begin
        case (state)
          BUSY: begin
            if (cnt == 4'd1) begin
              state_nxt = DONE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end
          DONE: begin
            if (grant) begin
              state_nxt = IDLE;
              tag_nxt   = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign idle = (state == IDLE);
  assign done = (state == DONE);
endmodule

module fu_issue_ctrl #(
  parameter int ROB_W   = `ROB_ENTRY_WIDTH,
  parameter int LAT_ALU = 1,
  parameter int LAT_MEM = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8,
  parameter int LAT_BRA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             valid_RO,
  input  logic [2:0]       FUType_RO,
  input  logic [ROB_W-1:0] ROB_dest_RO,
  input  logic             flush_req,
  output logic             issue_valid,
  output logic [2:0]       issue_FU,
  output logic             stall_RN,
  output logic             flush_RN,
  output logic             cdb_valid,
  output logic [2:0]       cdb_FU,
  output logic [ROB_W-1:0] cdb_ROB,
  output logic [4:0]       fu_busy
);
  localparam int NUM_FU = 5;
  // Unit k serves FUType k+1: ALU, MEM, MUL, DIV, BRA.
  localparam logic [NUM_FU-1:0][3:0] LATS =
    {4'(LAT_BRA), 4'(LAT_DIV), 4'(LAT_MUL), 4'(LAT_MEM), 4'(LAT_ALU)};

  if (LAT_ALU < 1 || LAT_ALU > 15 || LAT_MEM < 1 || LAT_MEM > 15 ||
      LAT_MUL < 1 || LAT_MUL > 15 || LAT_DIV < 1 || LAT_DIV > 15 ||
      LAT_BRA < 1 || LAT_BRA > 15) begin : g_lat_chk
    $error("fu_issue_ctrl: unit latency outside 1..15");
  end

  logic [NUM_FU-1:0]            idle, done, grant, tgt, issue;
  logic [NUM_FU-1:0][ROB_W-1:0] tag;
  logic                         live, nop, tgt_ok;

  // Issue and CDB are only allowed when enabled, not flushing, not in reset.
  assign live = EN & ~flush_req & rst;

  // Target decode; unknown FUTypes decode to no unit and are treated as NOPs.
  always_comb begin
    tgt = '0;
    case (FUType_RO)
      3'd1: tgt = 5'b00001;
      3'd2: tgt = 5'b00010;
      3'd3: tgt = 5'b00100;
      3'd4: tgt = 5'b01000;
      3'd5: tgt = 5'b10000;
      default: tgt = '0;
    endcase
  end
  assign nop = (tgt == '0);

  // Fixed-priority CDB arbiter: DIV > MUL > MEM > ALU > BRA.
  always_comb begin
    grant = '0;
    if (live) begin
      if      (done[3]) grant[3] = 1'b1;
      else if (done[2]) grant[2] = 1'b1;
      else if (done[1]) grant[1] = 1'b1;
      else if (done[0]) grant[0] = 1'b1;
      else if (done[4]) grant[4] = 1'b1;
    end
  end

  // CDB payload mux; zero when nothing is granted.
  always_comb begin
    cdb_FU  = '0;
    cdb_ROB = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (grant[k]) begin
        cdb_FU  = 3'(k + 1);
        cdb_ROB = tag[k];
      end
    end
  end
  assign cdb_valid = |grant;

  // A unit accepts when idle, or when it is retiring onto the CDB this cycle.
  assign tgt_ok      = |(tgt & (idle | (done & grant)));
  assign issue_valid = live & valid_RO & (nop | tgt_ok);
  assign issue_FU    = (issue_valid & ~nop) ? FUType_RO : 3'd0;
  assign issue       = issue_valid ? tgt : '0;
  assign stall_RN    = EN & valid_RO & ~issue_valid & ~flush_req;
  assign flush_RN    = flush_req;
  assign fu_busy     = ~idle;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    fu_unit #(.ROB_W(ROB_W), .LAT(LATS[k])) u_fu (
      .clk    (clk),
      .rst    (rst),
      .en     (EN),
      .flush  (flush_req),
      .issue  (issue[k]),
      .grant  (grant[k]),
      .tag_in (ROB_dest_RO),
      .idle   (idle[k]),
      .done   (done[k]),
      .tag    (tag[k])
    );
  end
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl with default latencies and 6-bit tags.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_fu_issue_ctrl;
  logic       clk, rst, EN, valid_RO, flush_req;
  logic [2:0] FUType_RO;
  logic [5:0] ROB_dest_RO;
  logic       issue_valid, stall_RN, flush_RN, cdb_valid;
  logic [2:0] issue_FU, cdb_FU;
  logic [5:0] cdb_ROB;
  logic [4:0] fu_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int seen;

  fu_issue_ctrl dut (
    .clk(clk), .rst(rst), .EN(EN), .valid_RO(valid_RO), .FUType_RO(FUType_RO),
    .ROB_dest_RO(ROB_dest_RO), .flush_req(flush_req), .issue_valid(issue_valid),
    .issue_FU(issue_FU), .stall_RN(stall_RN), .flush_RN(flush_RN),
    .cdb_valid(cdb_valid), .cdb_FU(cdb_FU), .cdb_ROB(cdb_ROB), .fu_busy(fu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, return for checks.
  task automatic drv(input logic en, input logic fl, input logic v,
                     input logic [2:0] f, input logic [5:0] t);
    @(negedge clk);
    EN = en; flush_req = fl; valid_RO = v; FUType_RO = f; ROB_dest_RO = t;
    #1;
  endtask

  task automatic idle_c();
    drv(1'b1, 1'b0, 1'b0, 3'd0, 6'd0);
  endtask

  initial begin
    // Reset with a live ALU request presented: nothing may issue or broadcast.
    rst = 1'b0; EN = 1'b1; flush_req = 1'b0; valid_RO = 1'b1;
    FUType_RO = 3'd1; ROB_dest_RO = 6'd5;
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_fu",    issue_FU,    0);
    chk("rst_fu_busy",     fu_busy,     0);
    chk("rst_cdb_valid",   cdb_valid,   0);
    chk("rst_cdb_rob",     cdb_ROB,     0);
    EN = 1'b0; valid_RO = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    // ALU tag 5: issue c0, broadcast c2, idle c3.
    drv(1, 0, 1, 3'd1, 6'd5);
    chk("alu_issue_valid", issue_valid, 1);
    chk("alu_issue_fu",    issue_FU,    1);
    chk("alu_stall",       stall_RN,    0);
    idle_c();
    chk("alu_busy_c1",     fu_busy,     5'b00001);
    chk("alu_nocdb_c1",    cdb_valid,   0);
    idle_c();
    chk("alu_cdb_valid",   cdb_valid,   1);
    chk("alu_cdb_fu",      cdb_FU,      1);
    chk("alu_cdb_rob",     cdb_ROB,     5);
    idle_c();
    chk("alu_busy_c3",     fu_busy,     0);
    chk("alu_cdb_off",     cdb_valid,   0);
    chk("alu_cdb_rob_off", cdb_ROB,     0);

    // NOP FUTypes issue immediately with no unit.
    drv(1, 0, 1, 3'd0, 6'd9);
    chk("nop0_issue",   issue_valid, 1);
    chk("nop0_fu",      issue_FU,    0);
    drv(1, 0, 1, 3'd7, 6'd9);
    chk("nop7_issue",   issue_valid, 1);
    chk("nop7_stall",   stall_RN,    0);
    idle_c();
    chk("nop_no_alloc", fu_busy,     0);

    // DIV tag 3, then DIV tag 4 waits 8 cycles and issues as tag 3 broadcasts.
    drv(1, 0, 1, 3'd4, 6'd3);
    chk("div_issue", issue_valid, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      drv(1, 0, 1, 3'd4, 6'd4);
      if (stall_RN && !issue_valid && !cdb_valid) seen++;
    end
    chk("div_stall_cycles", seen, 8);
    drv(1, 0, 1, 3'd4, 6'd4);
    chk("div_cdb_valid",  cdb_valid,   1);
    chk("div_cdb_fu",     cdb_FU,      4);
    chk("div_cdb_rob",    cdb_ROB,     3);
    chk("div_reissue",    issue_valid, 1);
    chk("div_reissue_st", stall_RN,    0);
    idle_c();
    chk("div2_busy", fu_busy, 5'b01000);
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      idle_c();
      if (cdb_valid) seen++;
    end
    chk("div2_quiet", seen, 0);
    idle_c();
    chk("div2_cdb_valid", cdb_valid, 1);
    chk("div2_cdb_rob",   cdb_ROB,   4);
    idle_c();
    chk("div2_idle", fu_busy, 0);

    // DIV tag 9 at c0 and MUL tag 7 at c5 both reach DONE at c9.
    drv(1, 0, 1, 3'd4, 6'd9);
    repeat (4) idle_c();
    drv(1, 0, 1, 3'd3, 6'd7);
    repeat (3) idle_c();
    chk("prio_both_busy", fu_busy, 5'b01100);
    drv(1, 0, 1, 3'd3, 6'd8);
    chk("prio_first_fu",  cdb_FU,      4);
    chk("prio_first_rob", cdb_ROB,     9);
    chk("prio_mul_stall", stall_RN,    1);
    chk("prio_mul_noiss", issue_valid, 0);
    drv(1, 0, 1, 3'd3, 6'd8);
    chk("prio_second_fu",  cdb_FU,      3);
    chk("prio_second_rob", cdb_ROB,     7);
    chk("prio_mul_reiss",  issue_FU,    3);
    idle_c();
    chk("prio_mul_busy", fu_busy,   5'b00100);
    chk("prio_cdb_off",  cdb_valid, 0);
    drv(1, 1, 0, 3'd0, 6'd0);
    idle_c();
    chk("prio_flushed", fu_busy, 0);

    // MEM tag 2 at c0, ALU tag 1 at c1: both DONE at c3, MEM wins.
    drv(1, 0, 1, 3'd2, 6'd2);
    drv(1, 0, 1, 3'd1, 6'd1);
    idle_c();
    idle_c();
    chk("memalu_first_fu",  cdb_FU,  2);
    chk("memalu_first_rob", cdb_ROB, 2);
    idle_c();
    chk("memalu_second_fu",  cdb_FU,  1);
    chk("memalu_second_rob", cdb_ROB, 1);
    idle_c();
    chk("memalu_idle", fu_busy, 0);

    // Flush while MEM and DIV are busy.
    drv(1, 0, 1, 3'd2, 6'd2);
    drv(1, 0, 1, 3'd4, 6'd6);
    drv(1, 1, 1, 3'd1, 6'd1);
    chk("flush_rn",     flush_RN,    1);
    chk("flush_noiss",  issue_valid, 0);
    chk("flush_nostl",  stall_RN,    0);
    chk("flush_busy",   fu_busy,     5'b01010);
    idle_c();
    chk("flush_idle",   fu_busy,     0);
    chk("flush_rn_off", flush_RN,    0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      idle_c();
      if (cdb_valid) seen++;
    end
    chk("flush_no_cdb", seen, 0);

    // Flush with EN low while ALU is DONE: flush_RN still passes, CDB blocked.
    drv(1, 0, 1, 3'd1, 6'd11);
    idle_c();
    drv(0, 1, 0, 3'd0, 6'd0);
    chk("flush_en0_rn",  flush_RN,  1);
    chk("flush_en0_cdb", cdb_valid, 0);
    idle_c();
    chk("flush_en0_idle", fu_busy,   0);
    chk("flush_en0_quiet", cdb_valid, 0);

    // MUL tag 1 frozen at cnt=2 for 4 cycles; CDB in the third cycle after EN
    // returns (EN back at c6, cnt 2->1 at c7, DONE at c8).
    drv(1, 0, 1, 3'd3, 6'd1);
    idle_c();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 3'd1, 6'd2);
      if (issue_valid || stall_RN || cdb_valid || fu_busy != 5'b00100) seen++;
    end
    chk("en_freeze", seen, 0);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      idle_c();
      if (cdb_valid) seen++;
    end
    chk("en_resume_quiet", seen, 0);
    idle_c();
    chk("en_resume_cdb", cdb_valid, 1);
    chk("en_resume_rob", cdb_ROB,   1);
    idle_c();
    chk("en_resume_idle", fu_busy, 0);

    // Asynchronous reset in the middle of a DIV.
    drv(1, 0, 1, 3'd4, 6'd10);
    idle_c();
    idle_c();
    chk("arst_pre_busy", fu_busy, 5'b01000);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy_now", fu_busy, 0);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      idle_c();
      if (cdb_valid) seen++;
    end
    chk("arst_no_cdb", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
